// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame sequencer.
package fft_pkg;

    typedef enum logic [2:0] {
        ST_RST_CORE = 3'd0,
        ST_IDLE     = 3'd1,
        ST_CONFIG   = 3'd2,
        ST_LOAD     = 3'd3,
        ST_UNLOAD   = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CORE_EVT = 2'd1;
    localparam logic [1:0] ERR_TLAST    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam int DEF_LOG2_NFFT = 9;
    localparam int DEF_CFG_W     = 8;

endpackage

// File: rtl/fft_frame_sequencer.sv
// Frame-level controller for an AXI-Stream FFT core: resets the core, sends
// the config word, streams one frame in, drains one frame out and reports
// completion, protocol errors and stalled unloads.
//
// Handshake rule on every stream: a beat transfers on the rising edge where
// tvalid and tready are both 1; the sequencer only gates valid/ready with
// the current state, sample and result data pass straight through.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2_NFFT  = DEF_LOG2_NFFT,
    parameter int DATA_W     = 32,
    parameter int CFG_W      = DEF_CFG_W,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic              Bus2IP_Clk,
    input  logic              Bus2IP_Reset,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    input  logic              cfg_fwd_inv,
    input  logic [CFG_W-2:0]  cfg_scale,
    input  logic              smp_tvalid,
    input  logic [DATA_W-1:0] smp_tdata,
    output logic              smp_tready,
    output logic              fft_aresetn,
    output logic              fft_cfg_tvalid,
    output logic [CFG_W-1:0]  fft_cfg_tdata,
    input  logic              fft_cfg_tready,
    output logic              fft_s_tvalid,
    output logic [DATA_W-1:0] fft_s_tdata,
    output logic              fft_s_tlast,
    input  logic              fft_s_tready,
    input  logic              fft_m_tvalid,
    input  logic              fft_m_tlast,
    output logic              fft_m_tready,
    output logic              res_tvalid,
    output logic              res_tlast,
    input  logic              res_tready,
    input  logic              ev_tlast_unexp,
    input  logic              ev_tlast_miss,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       frame_cnt,
    output state_e            dbg_state
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int RC_W  = $clog2(RST_CYCLES + 1);
    localparam logic [LOG2_NFFT-1:0] LAST_IDX = {LOG2_NFFT{1'b1}};
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [RC_W-1:0]      RC_LAST  = RC_W'(RST_CYCLES - 1);

    state_e               state_q;
    logic [RC_W-1:0]      rst_cnt_q;
    logic [LOG2_NFFT-1:0] in_cnt_q;
    logic [LOG2_NFFT-1:0] out_cnt_q;
    logic [TMO_W-1:0]     tmo_cnt_q;
    logic [CFG_W-1:0]     cfg_q;
    logic                 err_q;
    logic [1:0]           err_code_q;
    logic [15:0]          frame_cnt_q;

    logic       in_hs, out_hs, in_last, out_last, ev_any, in_frame;
    logic       start_ok, tmo_hit, err_hit;
    logic [1:0] err_hit_code;

    assign in_hs    = (state_q == ST_LOAD) && smp_tvalid && fft_s_tready;
    assign out_hs   = (state_q == ST_UNLOAD) && fft_m_tvalid && res_tready;
    assign in_last  = (in_cnt_q == LAST_IDX);
    assign out_last = (out_cnt_q == LAST_IDX);
    assign ev_any   = ev_tlast_unexp || ev_tlast_miss;
    assign in_frame = (state_q == ST_CONFIG) || (state_q == ST_LOAD) || (state_q == ST_UNLOAD);
    assign start_ok = (state_q == ST_IDLE) && cmd_start && !cmd_abort;
    assign tmo_hit  = (state_q == ST_UNLOAD) && !out_hs && (tmo_cnt_q == TMO_LAST);

    assign smp_tready     = (state_q == ST_LOAD) && fft_s_tready;
    assign fft_s_tvalid   = (state_q == ST_LOAD) && smp_tvalid;
    assign fft_s_tdata    = smp_tdata;
    assign fft_s_tlast    = (state_q == ST_LOAD) && in_last;
    assign fft_m_tready   = (state_q == ST_UNLOAD) && res_tready;
    assign res_tvalid     = (state_q == ST_UNLOAD) && fft_m_tvalid;
    assign res_tlast      = (state_q == ST_UNLOAD) && out_last;
    assign fft_cfg_tvalid = (state_q == ST_CONFIG);
    assign fft_cfg_tdata  = cfg_q;
    assign fft_aresetn    = (state_q != ST_RST_CORE);
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign err            = err_q;
    assign err_code       = err_code_q;
    assign frame_cnt      = frame_cnt_q;
    assign dbg_state      = state_q;

    // Classify this cycle's error source; core events outrank unload checks,
    // and an abort suppresses the unload checks it overrides.
    always_comb begin
        err_hit      = 1'b0;
        err_hit_code = ERR_NONE;
        if (in_frame && ev_any) begin
            err_hit      = 1'b1;
            err_hit_code = ERR_CORE_EVT;
        end else if ((state_q == ST_UNLOAD) && !cmd_abort) begin
            if (out_hs && (fft_m_tlast != out_last)) begin
                err_hit      = 1'b1;
                err_hit_code = ERR_TLAST;
            end else if (tmo_hit) begin
                err_hit      = 1'b1;
                err_hit_code = ERR_TIMEOUT;
            end
        end
    end

    // Frame FSM with its counters, config latch and sticky error state.
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state_q     <= ST_RST_CORE;
            rst_cnt_q   <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            cfg_q       <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            frame_cnt_q <= '0;
        end else begin
            if (start_ok) begin
                err_q      <= 1'b0;
                err_code_q <= ERR_NONE;
            end else if (err_hit) begin
                err_q <= 1'b1;
                if (!err_q) err_code_q <= err_hit_code;
            end

            case (state_q)
                ST_RST_CORE: begin
                    in_cnt_q  <= '0;
                    out_cnt_q <= '0;
                    tmo_cnt_q <= '0;
                    if (rst_cnt_q == RC_LAST) begin
                        rst_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RC_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (cmd_abort) begin
                        state_q <= ST_RST_CORE;
                    end else if (cmd_start) begin
                        cfg_q   <= {cfg_scale, cfg_fwd_inv};
                        state_q <= ST_CONFIG;
                    end
                end
                ST_CONFIG: begin
                    if (cmd_abort || ev_any) state_q <= ST_RST_CORE;
                    else if (fft_cfg_tready) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (cmd_abort || ev_any) begin
                        state_q <= ST_RST_CORE;
                    end else if (in_hs) begin
                        if (in_last) begin
                            in_cnt_q  <= '0;
                            tmo_cnt_q <= '0;
                            state_q   <= ST_UNLOAD;
                        end else begin
                            in_cnt_q <= in_cnt_q + LOG2_NFFT'(1);
                        end
                    end
                end
                ST_UNLOAD: begin
                    if (cmd_abort || ev_any || tmo_hit) begin
                        state_q <= ST_RST_CORE;
                    end else if (out_hs) begin
                        tmo_cnt_q <= '0;
                        if (out_last) begin
                            out_cnt_q   <= '0;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            state_q     <= ST_DONE;
                        end else begin
                            out_cnt_q <= out_cnt_q + LOG2_NFFT'(1);
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= cmd_abort ? ST_RST_CORE : ST_IDLE;
                end
                default: state_q <= ST_RST_CORE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for the FFT frame sequencer with NFFT=8, TIMEOUT=16.
// Inputs change 1 time unit after the rising edge; outputs are observed on
// the falling edge.
module tb_fft_frame_sequencer;
    import fft_pkg::*;

    localparam int LOG2_NFFT = 3;
    localparam int NFFT      = 8;
    localparam int DATA_W    = 32;
    localparam int CFG_W     = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_start = 1'b0, cmd_abort = 1'b0;
    logic              cfg_fwd_inv = 1'b0;
    logic [CFG_W-2:0]  cfg_scale = '0;
    logic              smp_tvalid = 1'b0;
    logic [DATA_W-1:0] smp_tdata = '0;
    logic              smp_tready;
    logic              fft_aresetn, fft_cfg_tvalid;
    logic [CFG_W-1:0]  fft_cfg_tdata;
    logic              fft_cfg_tready = 1'b0;
    logic              fft_s_tvalid, fft_s_tlast;
    logic [DATA_W-1:0] fft_s_tdata;
    logic              fft_s_tready = 1'b0;
    logic              fft_m_tvalid = 1'b0, fft_m_tlast = 1'b0;
    logic              fft_m_tready, res_tvalid, res_tlast;
    logic              res_tready = 1'b0;
    logic              ev_tlast_unexp = 1'b0, ev_tlast_miss = 1'b0;
    logic              busy, done, err;
    logic [1:0]        err_code;
    logic [15:0]       frame_cnt;
    state_e            dbg_state;

    int checks = 0;
    int errors = 0;

    // Monitor tallies, cleared per scenario
    int          cfg_hs_cnt, in_beats, tlast_cnt, tlast_pos;
    int          out_beats, rlast_cnt, rlast_pos, done_cnt, pass_bad;
    logic [7:0]  last_cfg;

    fft_frame_sequencer #(
        .LOG2_NFFT(LOG2_NFFT), .DATA_W(DATA_W), .CFG_W(CFG_W),
        .RST_CYCLES(2), .TIMEOUT(16)
    ) dut (
        .Bus2IP_Clk(clk), .Bus2IP_Reset(rst),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_fwd_inv(cfg_fwd_inv), .cfg_scale(cfg_scale),
        .smp_tvalid(smp_tvalid), .smp_tdata(smp_tdata), .smp_tready(smp_tready),
        .fft_aresetn(fft_aresetn),
        .fft_cfg_tvalid(fft_cfg_tvalid), .fft_cfg_tdata(fft_cfg_tdata), .fft_cfg_tready(fft_cfg_tready),
        .fft_s_tvalid(fft_s_tvalid), .fft_s_tdata(fft_s_tdata), .fft_s_tlast(fft_s_tlast),
        .fft_s_tready(fft_s_tready),
        .fft_m_tvalid(fft_m_tvalid), .fft_m_tlast(fft_m_tlast), .fft_m_tready(fft_m_tready),
        .res_tvalid(res_tvalid), .res_tlast(res_tlast), .res_tready(res_tready),
        .ev_tlast_unexp(ev_tlast_unexp), .ev_tlast_miss(ev_tlast_miss),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .frame_cnt(frame_cnt), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Handshake monitor on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (fft_cfg_tvalid && fft_cfg_tready) begin
                cfg_hs_cnt++;
                last_cfg = fft_cfg_tdata;
            end
            if (fft_s_tvalid && fft_s_tready) begin
                in_beats++;
                if (fft_s_tlast) begin tlast_cnt++; tlast_pos = in_beats; end
            end
            if (res_tvalid && res_tready) begin
                out_beats++;
                if (res_tlast) begin rlast_cnt++; rlast_pos = out_beats; end
            end
            if (done) done_cnt++;
            if (fft_s_tdata !== smp_tdata) pass_bad++;
            if (dbg_state == ST_LOAD && (fft_s_tvalid !== smp_tvalid || smp_tready !== fft_s_tready)) pass_bad++;
            if (dbg_state == ST_UNLOAD && (res_tvalid !== fft_m_tvalid || fft_m_tready !== res_tready)) pass_bad++;
        end
    end

    task automatic clear_mon();
        cfg_hs_cnt = 0; in_beats = 0; tlast_cnt = 0; tlast_pos = 0;
        out_beats = 0; rlast_cnt = 0; rlast_pos = 0; done_cnt = 0; pass_bad = 0;
        last_cfg = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Driver tasks
    task automatic start_frame(input logic fwd, input logic [6:0] scale);
        cfg_fwd_inv = fwd; cfg_scale = scale; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic do_config(input bit thr);
        int g = 0;
        while (cfg_hs_cnt == 0 && g < 50) begin
            fft_cfg_tready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            tick(); g++;
        end
        fft_cfg_tready = 1'b0;
        checks++;
        if (cfg_hs_cnt == 0) begin errors++; $display("FAIL cfg_wait: no config handshake within %0d cycles", g); end
    endtask

    task automatic do_load(input bit thr, input int target);
        int g = 0;
        while (in_beats < target && g < 400) begin
            smp_tvalid   = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            fft_s_tready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            smp_tdata    = $urandom;
            tick(); g++;
        end
        smp_tvalid = 1'b0; fft_s_tready = 1'b0;
    endtask

    task automatic do_unload(input bit thr, input int tlast_beat);
        int g = 0;
        while (out_beats < NFFT && g < 400) begin
            fft_m_tvalid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            res_tready   = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            fft_m_tlast  = (out_beats == tlast_beat - 1);
            tick(); g++;
        end
        fft_m_tvalid = 1'b0; res_tready = 1'b0; fft_m_tlast = 1'b0;
    endtask

    task automatic run_frame(input logic fwd, input logic [6:0] scale, input bit thr, input int tlast_beat);
        clear_mon();
        start_frame(fwd, scale);
        do_config(thr);
        do_load(thr, NFFT);
        do_unload(thr, tlast_beat);
        tick(); tick();
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 50) begin tick(); g++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_wait: busy still %0b after %0d cycles", busy, g); end
    endtask

    // Scenarios
    task automatic test_reset();
        int n = 0;
        int hs_bad = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({fft_aresetn, busy, done, err, err_code, frame_cnt} !== {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_outputs: aresetn=%0b busy=%0b done=%0b err=%0b code=%0d frames=%0d, expected 0 1 0 0 0 0",
                     fft_aresetn, busy, done, err, err_code, frame_cnt);
        end
        checks++;
        if (dbg_state !== ST_RST_CORE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_RST_CORE); end
        rst = 1'b0;
        while (!fft_aresetn && n < 10) begin
            if ({smp_tready, fft_cfg_tvalid, fft_s_tvalid, fft_m_tready, res_tvalid} !== 5'b0) hs_bad++;
            tick(); n++;
        end
        checks++;
        if (n != 2) begin errors++; $display("FAIL reset_aresetn_low: low for %0d cycles, expected 2", n); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++;
        if (hs_bad != 0) begin errors++; $display("FAIL reset_handshakes: %0d cycles with a handshake output high, expected 0", hs_bad); end
    endtask

    task automatic test_single_frame();
        run_frame(1'b1, 7'h13, 1'b0, NFFT);
        checks++;
        if (cfg_hs_cnt != 1) begin errors++; $display("FAIL single_cfg_count: got %0d expected 1", cfg_hs_cnt); end
        checks++;
        if (last_cfg !== 8'h27) begin errors++; $display("FAIL single_cfg_word: got %0h expected 27", last_cfg); end
        checks++;
        if (in_beats != 8 || tlast_cnt != 1 || tlast_pos != 8) begin
            errors++; $display("FAIL single_input: beats=%0d tlasts=%0d pos=%0d, expected 8 1 8", in_beats, tlast_cnt, tlast_pos);
        end
        checks++;
        if (out_beats != 8 || rlast_cnt != 1 || rlast_pos != 8) begin
            errors++; $display("FAIL single_output: beats=%0d tlasts=%0d pos=%0d, expected 8 1 8", out_beats, rlast_cnt, rlast_pos);
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL single_done: %0d done cycles, expected 1", done_cnt); end
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frame_cnt: got %0d expected 1", frame_cnt); end
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_status: err=%0b busy=%0b, expected 0 0", err, busy); end
        checks++;
        if (pass_bad != 0) begin errors++; $display("FAIL single_passthrough: %0d bad cycles, expected 0", pass_bad); end
    endtask

    task automatic test_idle_events();
        ev_tlast_unexp = 1'b1; ev_tlast_miss = 1'b1;
        tick();
        ev_tlast_unexp = 1'b0; ev_tlast_miss = 1'b0;
        tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_events: err=%0b busy=%0b, expected 0 0", err, busy); end
    endtask

    task automatic test_back_to_back();
        logic       fwd_t [3]  = '{1'b0, 1'b1, 1'b0};
        logic [6:0] scl_t [3]  = '{7'h55, 7'h00, 7'h7F};
        logic [7:0] word_t [3] = '{8'hAA, 8'h01, 8'hFE};
        for (int f = 0; f < 3; f++) begin
            run_frame(fwd_t[f], scl_t[f], 1'b1, NFFT);
            checks++;
            if (cfg_hs_cnt != 1 || last_cfg !== word_t[f]) begin
                errors++; $display("FAIL b2b_cfg[%0d]: count=%0d word=%0h, expected 1 %0h", f, cfg_hs_cnt, last_cfg, word_t[f]);
            end
            checks++;
            if (in_beats != 8 || tlast_pos != 8 || out_beats != 8 || rlast_pos != 8 || done_cnt != 1) begin
                errors++;
                $display("FAIL b2b_counts[%0d]: in=%0d tl=%0d out=%0d rl=%0d done=%0d, expected 8 8 8 8 1",
                         f, in_beats, tlast_pos, out_beats, rlast_pos, done_cnt);
            end
            checks++;
            if (pass_bad != 0) begin errors++; $display("FAIL b2b_passthrough[%0d]: %0d bad cycles, expected 0", f, pass_bad); end
        end
        checks++;
        if (frame_cnt !== 16'd4) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected 4", frame_cnt); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %0b expected 0", err); end
    endtask

    task automatic test_tlast_early();
        run_frame(1'b1, 7'h01, 1'b0, 5);
        checks++;
        if (err !== 1'b1 || err_code !== ERR_TLAST) begin
            errors++; $display("FAIL tlast_err: err=%0b code=%0d, expected 1 2", err, err_code);
        end
        checks++;
        if (done_cnt != 1 || frame_cnt !== 16'd5) begin
            errors++; $display("FAIL tlast_done: done=%0d frames=%0d, expected 1 5", done_cnt, frame_cnt);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int m = 0;
        clear_mon();
        start_frame(1'b0, 7'h02);
        do_config(1'b0);
        do_load(1'b0, NFFT);
        fft_m_tvalid = 1'b1; res_tready = 1'b0;
        while (fft_aresetn && n < 40) begin tick(); n++; end
        fft_m_tvalid = 1'b0;
        checks++;
        if (n != 16) begin errors++; $display("FAIL timeout_cycles: timed out after %0d cycles, expected 16", n); end
        while (!fft_aresetn && m < 10) begin tick(); m++; end
        checks++;
        if (m != 2) begin errors++; $display("FAIL timeout_core_reset: aresetn low %0d cycles, expected 2", m); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy=%0b expected 0", busy); end
        checks++;
        if (err !== 1'b1 || err_code !== ERR_TIMEOUT) begin
            errors++; $display("FAIL timeout_err: err=%0b code=%0d, expected 1 3", err, err_code);
        end
        checks++;
        if (done_cnt != 0 || out_beats != 0 || frame_cnt !== 16'd5) begin
            errors++; $display("FAIL timeout_frame: done=%0d out=%0d frames=%0d, expected 0 0 5", done_cnt, out_beats, frame_cnt);
        end
    endtask

    task automatic test_abort_event();
        clear_mon();
        start_frame(1'b1, 7'h04);
        do_config(1'b0);
        do_load(1'b0, 3);
        cmd_abort = 1'b1; ev_tlast_miss = 1'b1;
        tick();
        cmd_abort = 1'b0; ev_tlast_miss = 1'b0;
        checks++;
        if (fft_aresetn !== 1'b0 || dbg_state !== ST_RST_CORE) begin
            errors++; $display("FAIL abort_rst_core: aresetn=%0b state=%0d, expected 0 %0d", fft_aresetn, dbg_state, ST_RST_CORE);
        end
        checks++;
        if (err !== 1'b1 || err_code !== ERR_CORE_EVT) begin
            errors++; $display("FAIL abort_err: err=%0b code=%0d, expected 1 1", err, err_code);
        end
        wait_idle();
        checks++;
        if (done_cnt != 0 || frame_cnt !== 16'd5 || in_beats != 3) begin
            errors++; $display("FAIL abort_frame: done=%0d frames=%0d in=%0d, expected 0 5 3", done_cnt, frame_cnt, in_beats);
        end
        // A fresh frame after the abort must start its counts from zero
        run_frame(1'b1, 7'h13, 1'b0, NFFT);
        checks++;
        if (tlast_pos != 8 || rlast_pos != 8 || done_cnt != 1 || frame_cnt !== 16'd6 || err !== 1'b0) begin
            errors++;
            $display("FAIL post_abort_frame: tl=%0d rl=%0d done=%0d frames=%0d err=%0b, expected 8 8 1 6 0",
                     tlast_pos, rlast_pos, done_cnt, frame_cnt, err);
        end
    endtask

    // Sequence and report
    initial begin
        clear_mon();
        test_reset();
        test_single_frame();
        test_idle_events();
        test_back_to_back();
        test_tlast_early();
        test_timeout();
        test_abort_event();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
